mod_top: RTL and testbench



---
 rtl/mod_top.sv | 82 ++++++++
 tb/tb_mod_top.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_top.sv
// mod_top: APB3 slave with ID/SRST/STATUS/PER_DATA/RESULT registers and an MSB-first loopback shifter; MOD_TOP_PARITY_EN adds a STATUS[2] PER_DATA parity bit
module mod_top #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter     ID_VALUE   = 8'hA5
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PSELx,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [DATA_WIDTH-1:0] ID = DATA_WIDTH'(ID_VALUE);
  logic                  acc, acc_d, first, srst, launch;
  logic [DATA_WIDTH-1:0] per_data, result, tx, rx, rx_nxt, status;
  logic [CW-1:0]         cnt;
  logic                  busy, done;
  assign acc    = PSELx & PENABLE;
  assign first  = acc & ~acc_d;
  assign launch = first & PWRITE & (PADDR == ADDR_WIDTH'(4));
  assign rx_nxt = {rx[DATA_WIDTH-2:0], tx[DATA_WIDTH-1]};
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      acc_d    <= 1'b0;
      srst     <= 1'b0;
      per_data <= '0;
      result   <= '0;
      tx       <= '0;
      rx       <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      acc_d <= acc;
      srst  <= first & PWRITE & (PADDR == ADDR_WIDTH'(1)) & PWDATA[0];
      if (srst) begin
        per_data <= '0;
        result   <= '0;
        tx       <= '0;
        rx       <= '0;
        cnt      <= '0;
        busy     <= 1'b0;
        done     <= 1'b0;
      end else begin
        if (acc && PWRITE && PADDR == ADDR_WIDTH'(4))
          per_data <= PWDATA;
        if (launch) begin
          tx   <= PWDATA;
          rx   <= '0;
          cnt  <= CW'(DATA_WIDTH);
          busy <= 1'b1;
          done <= 1'b0;
        end else if (busy) begin
          rx  <= rx_nxt;
          tx  <= tx << 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result <= rx_nxt;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
      end
    end
  always_comb begin
    status    = '0;
    status[0] = busy;
    status[1] = done;
`ifdef MOD_TOP_PARITY_EN
    status[2] = ^per_data;
`endif
    PRDATA = !(PSELx && !PWRITE)          ? '0 :
             PADDR == ADDR_WIDTH'(0)      ? ID :
             PADDR == ADDR_WIDTH'(2)      ? status :
             PADDR == ADDR_WIDTH'(4)      ? per_data :
             PADDR == ADDR_WIDTH'(5)      ? result : '0;
  end
endmodule

// File: tb/tb_mod_top.sv
// tb_mod_top: scoreboard-driven bench for the mod_top APB register file and loopback shifter
module tb_mod_top;
  logic       PCLK = 1'b0, PRESETn = 1'b0, PSELx = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0] PADDR = '0, PWDATA = '0;
  logic [7:0] PRDATA;
  int         passed = 0, total = 0;
  logic [7:0] exp_q[$];
  mod_top dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSELx(PSELx),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA)
  );
  always #5 PCLK = ~PCLK;
  task automatic apb_write(input logic [7:0] a, input logic [7:0] d, input int hold);
    @(posedge PCLK); #1;
    PSELx = 1; PWRITE = 1; PENABLE = 0; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1;
    repeat (hold) @(posedge PCLK);
    #1;
    PSELx = 0; PENABLE = 0; PWRITE = 0;
  endtask
  task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
    @(posedge PCLK); #1;
    PSELx = 1; PWRITE = 0; PENABLE = 0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1;
    #1 d = PRDATA;
    @(posedge PCLK); #1;
    PSELx = 0; PENABLE = 0;
  endtask
  task automatic peek(input logic [7:0] a, output logic [7:0] d);
    PSELx = 1; PWRITE = 0; PENABLE = 0; PADDR = a;
    #1 d = PRDATA;
    PSELx = 0;
  endtask
  task automatic wait_idle(input int start, output int n);
    logic [7:0] s;
    n = start;
    peek(8'h2, s);
    while (s[0] && n < 50) begin
      @(posedge PCLK); #1;
      n++;
      peek(8'h2, s);
    end
  endtask
  task automatic test_reset;
    logic [7:0] pa[3] = '{8'h4, 8'h2, 8'h5};
    logic [7:0] ra[3] = '{8'h0, 8'h2, 8'h4};
    logic [7:0] re[3] = '{8'hA5, 8'h00, 8'h00};
    logic [7:0] got, e;
    int n;
    PRESETn = 0;
    repeat (2) @(posedge PCLK);
    #3 PRESETn = 1;
    apb_write(8'h4, 8'h5A, 1);
    wait_idle(0, n);
    apb_write(8'h4, 8'h11, 1);
    repeat (3) @(posedge PCLK);
    #3 PRESETn = 0;
    #1;
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < 3; i++) begin
      peek(pa[i], got);
      e = exp_q.pop_front();
      total++;
      if (got !== e) $display("FAIL reset_async addr %h: got %h expected %h", pa[i], got, e);
      else passed++;
    end
    #10 PRESETn = 1;
    for (int i = 0; i < 3; i++) exp_q.push_back(re[i]);
    for (int i = 0; i < 3; i++) begin
      apb_read(ra[i], got);
      e = exp_q.pop_front();
      total++;
      if (got !== e) $display("FAIL reset_read addr %h: got %h expected %h", ra[i], got, e);
      else passed++;
    end
  endtask
  task automatic test_held_write;
    logic [7:0] got, e;
    int n;
    apb_write(8'h4, 8'h90, 4);
    wait_idle(3, n);
    total++;
    if (n !== 8) $display("FAIL held_busy_cycles: got %0d expected 8", n);
    else passed++;
    exp_q.push_back(8'h90);
    exp_q.push_back(8'h02);
    apb_read(8'h5, got);
    e = exp_q.pop_front();
    total++;
    if (got !== e) $display("FAIL held_result: got %h expected %h", got, e);
    else passed++;
    apb_read(8'h2, got);
    e = exp_q.pop_front();
    total++;
    if (got !== e) $display("FAIL held_status: got %h expected %h", got, e);
    else passed++;
  endtask
  task automatic test_readback;
    logic [7:0] got, e;
    exp_q.push_back(8'h90);
    apb_read(8'h4, got);
    e = exp_q.pop_front();
    total++;
    if (got !== e) $display("FAIL readback_per_data: got %h expected %h", got, e);
    else passed++;
    exp_q.push_back(8'h00);
    PSELx = 0; PWRITE = 0; PADDR = 8'h4;
    #1 got = PRDATA;
    e = exp_q.pop_front();
    total++;
    if (got !== e) $display("FAIL readback_unselected: got %h expected %h", got, e);
    else passed++;
  endtask
  task automatic test_restart;
    logic [7:0] got, e, s;
    int n;
    bit seen;
    apb_write(8'h4, 8'h3C, 1);
    repeat (3) @(posedge PCLK);
    apb_write(8'h4, 8'h81, 1);
    exp_q.push_back(8'h90);
    peek(8'h5, got);
    e = exp_q.pop_front();
    total++;
    if (got !== e) $display("FAIL restart_old_result: got %h expected %h", got, e);
    else passed++;
    n = 0;
    seen = 0;
    peek(8'h2, s);
    while (s[0] && n < 50) begin
      @(posedge PCLK); #1;
      n++;
      peek(8'h5, got);
      if (got === 8'h3C) seen = 1;
      peek(8'h2, s);
    end
    total++;
    if (n !== 8) $display("FAIL restart_busy_cycles: got %0d expected 8", n);
    else passed++;
    total++;
    if (seen !== 1'b0) $display("FAIL restart_aborted_value: got %b expected 0", seen);
    else passed++;
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h02);
    apb_read(8'h5, got);
    e = exp_q.pop_front();
    total++;
    if (got !== e) $display("FAIL restart_result: got %h expected %h", got, e);
    else passed++;
    apb_read(8'h2, got);
    e = exp_q.pop_front();
    total++;
    if (got !== e) $display("FAIL restart_status: got %h expected %h", got, e);
    else passed++;
  endtask
  task automatic test_srst;
    logic [7:0] ra[4] = '{8'h4, 8'h5, 8'h2, 8'h1};
    logic [7:0] got, e;
    apb_write(8'h1, 8'h01, 1);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) begin
      apb_read(ra[i], got);
      e = exp_q.pop_front();
      total++;
      if (got !== e) $display("FAIL srst addr %h: got %h expected %h", ra[i], got, e);
      else passed++;
    end
  endtask
  task automatic test_ignored;
    logic [7:0] ra[3] = '{8'h7, 8'h5, 8'h4};
    logic [7:0] re[3] = '{8'h00, 8'h6B, 8'h6B};
    logic [7:0] got, e;
    int n;
    apb_write(8'h4, 8'h6B, 1);
    wait_idle(0, n);
    apb_write(8'h7, 8'hFF, 1);
    apb_write(8'h5, 8'h55, 1);
    for (int i = 0; i < 3; i++) exp_q.push_back(re[i]);
    for (int i = 0; i < 3; i++) begin
      apb_read(ra[i], got);
      e = exp_q.pop_front();
      total++;
      if (got !== e) $display("FAIL ignored addr %h: got %h expected %h", ra[i], got, e);
      else passed++;
    end
  endtask
  initial begin
    test_reset();
    test_held_write();
    test_readback();
    test_restart();
    test_srst();
    test_ignored();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1);
  end
endmodule
